difftest_commit_stage: RTL

//  Sits between the writeback stage and difftest_commit. Buffers retiring instructions in a

---
 rtl/difftest_commit_stage_pkg.sv | 28 ++
 rtl/difftest_commit_stage_commit_fifo.sv | 63 ++++++
 rtl/difftest_commit_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/difftest_commit_stage_pkg.sv
// Shared types and constants for the difftest commit stage.
//   data_length    : architectural register / pc width
//   GPR_NUM        : number of general purpose registers (x0..x31)
//   EBREAK_INST    : instruction encoding that halts intake
//   commit_entry_t : one retiring instruction as held in the commit FIFO
//   state_e        : commit stage FSM states
package difftest_commit_stage_pkg;

   localparam int data_length = 64;
   localparam int GPR_NUM     = 32;
   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

   typedef struct packed {
      logic [data_length-1:0] pc;
      logic [data_length-1:0] next_pc;
      logic [31:0]            inst;
      logic                   rd_wen;
      logic [4:0]             rd_addr;
      logic [data_length-1:0] rd_data;
   } commit_entry_t;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_HALT    = 2'd1,
      ST_TIMEOUT = 2'd2
   } state_e;

endpackage

// File: rtl/difftest_commit_stage_commit_fifo.sv
// Synchronous FIFO of commit entries with asynchronous active-high reset.
//   clock, reset : clock, async active-high reset (empties the FIFO)
//   push         : write push_data this edge (honoured when not full, or when
//                  a pop frees a slot in the same cycle)
//   push_data    : entry to enqueue
//   pop          : remove the head entry this edge (ignored when empty)
//   pop_data     : current head entry (valid while ~empty)
//   full, empty  : occupancy flags
//   count        : number of stored entries, 0..DEPTH
module commit_fifo
   import difftest_commit_stage_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  commit_entry_t            push_data,
   input  logic                     pop,
   output commit_entry_t            pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   commit_entry_t    mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   // Pointers are exactly log2(DEPTH) bits so they wrap without compare logic.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: nothing is read unless count says it was written.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/difftest_commit_stage.sv
// Commit stage between writeback and difftest_commit. Buffers retiring
// instructions, applies rd writes to a shadow GPR file as each one drains,
// and presents pc/debug_pc/gpr_wire so every commit pulse shows post-write
// state. Halts intake on ebreak, counts retirements and runs a watchdog.
//   clock, reset      : clock, async active-high reset
//   wb_valid/wb_ready : writeback handshake, transfer when both high
//   wb_pc, wb_next_pc, wb_inst, wb_rd_wen, wb_rd_addr, wb_rd_data : retiring instr
//   sink_ready        : difftest_commit can take a commit
//   inst_commit       : one-cycle commit pulse
//   pc, debug_pc      : pc / next pc of the committed instruction
//   gpr_wire          : shadow GPRs, reg i at [64*i+63:64*i]
//   cpu_ebreak_sign   : pulses with the ebreak's commit
//   retired_cnt       : commits since reset (wraps)
//   timeout           : sticky watchdog flag
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_RUN     | accepting instructions, watchdog counting idle cycles
// ST_HALT    | ebreak enqueued; intake closed, FIFO drains normally
// ST_TIMEOUT | no commit for TIMEOUT cycles; intake closed, sticky
module difftest_commit_stage #(
   parameter int          DEPTH       = 4,
   parameter int          TIMEOUT     = 100000,
   parameter logic [31:0] EBREAK_INST = difftest_commit_stage_pkg::EBREAK_INST
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          wb_valid,
   output logic          wb_ready,
   input  logic [63:0]   wb_pc,
   input  logic [63:0]   wb_next_pc,
   input  logic [31:0]   wb_inst,
   input  logic          wb_rd_wen,
   input  logic [4:0]    wb_rd_addr,
   input  logic [63:0]   wb_rd_data,
   input  logic          sink_ready,
   output logic          inst_commit,
   output logic [63:0]   pc,
   output logic [63:0]   debug_pc,
   output logic [2047:0] gpr_wire,
   output logic          cpu_ebreak_sign,
   output logic [63:0]   retired_cnt,
   output logic          timeout
);

   import difftest_commit_stage_pkg::*;

   localparam int CNT_W  = $clog2(DEPTH) + 1;
   localparam int IDLE_W = $clog2(TIMEOUT + 1);

   state_e               state_q;
   logic [IDLE_W-1:0]    idle_q;
   logic [IDLE_W-1:0]    idle_nxt;
   logic [data_length-1:0] gpr_q [GPR_NUM];

   commit_entry_t        wb_entry;
   commit_entry_t        head;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [CNT_W-1:0]     fifo_count;

   assign wb_entry = '{pc:      wb_pc,
                       next_pc: wb_next_pc,
                       inst:    wb_inst,
                       rd_wen:  wb_rd_wen,
                       rd_addr: wb_rd_addr,
                       rd_data: wb_rd_data};

   assign wb_ready  = (state_q == ST_RUN) & ~fifo_full;
   assign fifo_push = wb_valid & wb_ready;
   assign fifo_pop  = ~fifo_empty & sink_ready;

   commit_fifo #(.DEPTH(DEPTH)) u_commit_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (wb_entry),
      .pop       (fifo_pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   always_comb begin
      assert (fifo_count <= CNT_W'(DEPTH));
   end

   // Saturating idle count; a dequeue restarts it.
   always_comb begin
      idle_nxt = idle_q;
      if (fifo_pop)
         idle_nxt = '0;
      else if (idle_q != IDLE_W'(TIMEOUT))
         idle_nxt = idle_q + IDLE_W'(1);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q         <= ST_RUN;
         idle_q          <= '0;
         inst_commit     <= 1'b0;
         pc              <= '0;
         debug_pc        <= '0;
         cpu_ebreak_sign <= 1'b0;
         retired_cnt     <= '0;
         timeout         <= 1'b0;
      end else begin
         inst_commit     <= fifo_pop;
         cpu_ebreak_sign <= fifo_pop & (head.inst == EBREAK_INST);
         if (fifo_pop) begin
            pc          <= head.pc;
            debug_pc    <= head.next_pc;
            retired_cnt <= retired_cnt + 64'd1;
         end
         case (state_q)
            ST_RUN: begin
               // An ebreak being accepted wins over a watchdog trip on the same edge.
               if (fifo_push && (wb_inst == EBREAK_INST)) begin
                  state_q <= ST_HALT;
                  idle_q  <= '0;
               end else if (idle_nxt == IDLE_W'(TIMEOUT)) begin
                  state_q <= ST_TIMEOUT;
                  timeout <= 1'b1;
                  idle_q  <= idle_nxt;
               end else begin
                  idle_q  <= idle_nxt;
               end
            end
            ST_HALT:    idle_q <= '0;
            ST_TIMEOUT: idle_q <= idle_q;
            default:    state_q <= ST_RUN;
         endcase
      end
   end

   // Shadow GPRs; x0 is never written so it always reads back as zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < GPR_NUM; i++) gpr_q[i] <= '0;
      end else if (fifo_pop && head.rd_wen && (head.rd_addr != 5'd0)) begin
         gpr_q[head.rd_addr] <= head.rd_data;
      end
   end

   always_comb begin
      gpr_wire = '0;
      for (int i = 0; i < GPR_NUM; i++) gpr_wire[64*i +: 64] = gpr_q[i];
   end

endmodule
